// File: rtl/wam_pkg.sv
// Level tables and shared types for the whack-a-mole level controller.
package wam_pkg;

    localparam int unsigned LVL_TW = 4;
    localparam int unsigned AGE_W  = 4;
    localparam int unsigned RTO_W  = 8;

    typedef logic [LVL_TW-1:0] lvl_t;

    // Entry 0 is level 1, entry 7 is level 8.
    localparam logic [7:0][AGE_W-1:0] AGE_TBL = {
        4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4, 4'd6, 4'd9
    };
    localparam logic [7:0][RTO_W-1:0] RTO_TBL = {
        8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd195, 8'd120
    };

    // Map a 1-based level onto a table slot.
    function automatic logic [2:0] tbl_idx(lvl_t l);
        return 3'(l - lvl_t'(1));
    endfunction

endpackage

// File: rtl/wam_lvl_if.sv
// Button inputs and level outputs of wam_lvl.
interface wam_lvl_if
    import wam_pkg::*;
#(
    parameter int unsigned LVL_W = 3
);
    logic             start;
    logic             lft;
    logic             rgt;
    logic             cout0;
    logic [LVL_W-1:0] lvl;
    logic [AGE_W-1:0] age;
    logic [RTO_W-1:0] rto;
    logic             lvl_chg;
    logic             at_min;
    logic             at_max;

    modport master (
        output start, lft, rgt, cout0,
        input  lvl, age, rto, lvl_chg, at_min, at_max
    );

    modport slave (
        input  start, lft, rgt, cout0,
        output lvl, age, rto, lvl_chg, at_min, at_max
    );
endinterface

// File: rtl/wam_dbn.sv
// Synchroniser + debouncer producing one pulse per press.
// WAM_LVL_AUTORPT_EN adds a held-button repeat pulse every RPT_CYC cycles
// (only for instances with RPT_OK set).
module wam_dbn #(
    parameter int unsigned DBN_CYC = 5
`ifdef WAM_LVL_AUTORPT_EN
    ,
    parameter int unsigned RPT_CYC = 16,
    parameter bit          RPT_OK  = 1'b1
`endif
) (
    input  logic clk_19,
    input  logic rst_n,
    input  logic raw,
    output logic pulse
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DBN_CYC - 1);

    logic             s1;
    logic             s2;
    logic [1:0]       warm;
    logic             prime;
    logic [CNT_W-1:0] cnt;
    logic             done;

`ifdef WAM_LVL_AUTORPT_EN
    localparam int unsigned RPT_W = 8;
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(RPT_CYC - 1);
    logic [RPT_W-1:0] rpt;
`endif

    // warm marks when s2 carries a real sample after reset; prime means the
    // last real sample was low, so a high sample now is a genuine rising edge.
    always_ff @(posedge clk_19 or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            warm  <= 2'b00;
            prime <= 1'b0;
            cnt   <= '0;
            done  <= 1'b0;
            pulse <= 1'b0;
`ifdef WAM_LVL_AUTORPT_EN
            rpt   <= '0;
`endif
        end else begin
            s1    <= raw;
            s2    <= s1;
            warm  <= {warm[0], 1'b1};
            pulse <= 1'b0;
            if (!s2) begin
                cnt   <= '0;
                done  <= 1'b0;
                prime <= warm[1];
`ifdef WAM_LVL_AUTORPT_EN
                rpt   <= '0;
`endif
            end else begin
                prime <= 1'b0;
                if (!done) begin
                    if (cnt == '0) begin
                        if (prime) begin
                            cnt <= CNT_W'(1);
                        end
                    end else if (cnt == CNT_LAST) begin
                        pulse <= 1'b1;
                        done  <= 1'b1;
                        cnt   <= '0;
`ifdef WAM_LVL_AUTORPT_EN
                        rpt   <= '0;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`ifdef WAM_LVL_AUTORPT_EN
                else if (RPT_OK) begin
                    if (rpt == RPT_LAST) begin
                        pulse <= 1'b1;
                        rpt   <= '0;
                    end else begin
                        rpt <= rpt + RPT_W'(1);
                    end
                end
`endif
            end
        end
    end

endmodule

// File: rtl/wam_lvl.sv
// Difficulty level controller: debounced easier/harder requests step a
// saturating level that drives mole lifetime and pop-up ratio tables.
// Optional macro WAM_LVL_AUTORPT_EN enables held-button repeat on lft/rgt.
module wam_lvl
    import wam_pkg::*;
#(
    parameter int unsigned NUM_LVL = 3,
    parameter int unsigned DBN_CYC = 5,
    parameter int unsigned RPT_CYC = 16,
    parameter int unsigned LVL_W   = 3
) (
    input  logic      clk_19,
    input  logic      rst_n,
    wam_lvl_if.slave  bus
);

    localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_TOP = LVL_W'(NUM_LVL);

    // Reject configurations outside the supported range at elaboration.
    if ((NUM_LVL < 2) || (NUM_LVL > 8) || (DBN_CYC < 2) || (DBN_CYC > 15) ||
        (RPT_CYC < 4) || (RPT_CYC > 255) || (NUM_LVL >= (1 << LVL_W))) begin : g_bad_cfg
        $error("wam_lvl: illegal parameter set");
    end

    logic             lft_p;
    logic             rgt_p;
    logic             cout_p;
    logic [LVL_W-1:0] lvl_q;
    logic [LVL_W-1:0] lvl_nx;
    logic [AGE_W-1:0] age_q;
    logic [RTO_W-1:0] rto_q;
    logic             chg_q;

    wam_dbn #(
        .DBN_CYC (DBN_CYC)
`ifdef WAM_LVL_AUTORPT_EN
        , .RPT_CYC (RPT_CYC), .RPT_OK (1'b1)
`endif
    ) u_dbn_lft (
        .clk_19 (clk_19),
        .rst_n  (rst_n),
        .raw    (bus.lft),
        .pulse  (lft_p)
    );

    wam_dbn #(
        .DBN_CYC (DBN_CYC)
`ifdef WAM_LVL_AUTORPT_EN
        , .RPT_CYC (RPT_CYC), .RPT_OK (1'b1)
`endif
    ) u_dbn_rgt (
        .clk_19 (clk_19),
        .rst_n  (rst_n),
        .raw    (bus.rgt),
        .pulse  (rgt_p)
    );

    // Score carry requests never repeat.
    wam_dbn #(
        .DBN_CYC (DBN_CYC)
`ifdef WAM_LVL_AUTORPT_EN
        , .RPT_CYC (RPT_CYC), .RPT_OK (1'b0)
`endif
    ) u_dbn_cout (
        .clk_19 (clk_19),
        .rst_n  (rst_n),
        .raw    (bus.cout0),
        .pulse  (cout_p)
    );

    // Next level: start beats easier beats harder; both directions saturate.
    always_comb begin
        lvl_nx = lvl_q;
        if (bus.start) begin
            lvl_nx = LVL_ONE;
        end else if (lft_p) begin
            if (lvl_q > LVL_ONE) begin
                lvl_nx = lvl_q - LVL_ONE;
            end
        end else if (rgt_p || cout_p) begin
            if (lvl_q < LVL_TOP) begin
                lvl_nx = lvl_q + LVL_ONE;
            end
        end
    end

    // Level and its table lookups update together so age/rto never lag lvl.
    always_ff @(posedge clk_19 or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q <= LVL_ONE;
            age_q <= AGE_TBL[0];
            rto_q <= RTO_TBL[0];
            chg_q <= 1'b0;
        end else begin
            lvl_q <= lvl_nx;
            age_q <= AGE_TBL[tbl_idx(lvl_t'(lvl_nx))];
            rto_q <= RTO_TBL[tbl_idx(lvl_t'(lvl_nx))];
            chg_q <= (lvl_nx != lvl_q);
        end
    end

    assign bus.lvl     = lvl_q;
    assign bus.age     = age_q;
    assign bus.rto     = rto_q;
    assign bus.lvl_chg = chg_q;
    assign bus.at_min  = (lvl_q == LVL_ONE);
    assign bus.at_max  = (lvl_q == LVL_TOP);

endmodule

// File: tb/tb_wam_lvl.sv
// Directed bench for wam_lvl with a press-timing reference model.
module tb_wam_lvl;

`ifdef WAM_LVL_AUTORPT_EN
    localparam int unsigned NUM_LVL = 8;
    localparam int unsigned LVL_W   = 4;
    localparam bit          AUTORPT = 1'b1;
`else
    localparam int unsigned NUM_LVL = 3;
    localparam int unsigned LVL_W   = 3;
    localparam bit          AUTORPT = 1'b0;
`endif
    localparam int unsigned DBN = 5;
    localparam int unsigned RPT = 16;

    logic clk_19 = 1'b0;
    logic rst_n;
    always #5 clk_19 = ~clk_19;

    wam_lvl_if #(.LVL_W(LVL_W)) bus ();

    wam_lvl #(
        .NUM_LVL (NUM_LVL),
        .DBN_CYC (DBN),
        .RPT_CYC (RPT),
        .LVL_W   (LVL_W)
    ) dut (
        .clk_19 (clk_19),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    // Reference model: a press is a run of raw high samples that began after a
    // low sample seen since reset. It is accepted when the run hits DBN (and
    // every RPT samples later for repeating buttons); the level moves three
    // edges after that sample (two sync stages plus the pulse register).
    typedef struct packed {
        logic [2:0][15:0] run;
        logic [2:0]       armed;
        logic [2:0]       ev0;
        logic [2:0]       ev1;
        logic [2:0]       ev2;
        logic [3:0]       lvl;
        logic             chg;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mdl_rst();
        mdl_t r;
        r     = '0;
        r.lvl = 4'd1;
        return r;
    endfunction

    function automatic mdl_t step(mdl_t c, logic [2:0] raw, logic st);
        mdl_t       n;
        logic [2:0] hit;
        logic [2:0] app;
        int         r;
        int         nl;
        n   = c;
        hit = '0;
        for (int i = 0; i < 3; i++) begin
            if (!raw[i]) begin
                n.run[i]   = '0;
                n.armed[i] = 1'b1;
            end else if (c.armed[i]) begin
                r          = int'(c.run[i]) + 1;
                n.run[i]   = 16'(r);
                hit[i]     = (r == int'(DBN)) ||
                             (AUTORPT && (i != 2) && (r > int'(DBN)) &&
                              (((r - int'(DBN)) % int'(RPT)) == 0));
            end
        end
        app   = c.ev2;
        n.ev2 = c.ev1;
        n.ev1 = c.ev0;
        n.ev0 = hit;
        nl    = int'(c.lvl);
        if (st)                  nl = 1;
        else if (app[0])         nl = (nl > 1) ? nl - 1 : 1;
        else if (app[1] | app[2]) nl = (nl < int'(NUM_LVL)) ? nl + 1 : nl;
        n.chg = (nl != int'(c.lvl));
        n.lvl = 4'(nl);
        return n;
    endfunction

    always @(posedge clk_19 or negedge rst_n) begin
        if (!rst_n) m <= mdl_rst();
        else        m <= step(m, {bus.cout0, bus.rgt, bus.lft}, bus.start);
    end

    function automatic int age_exp(int l);
        case (l)
            1: return 9;
            2: return 6;
            3: return 4;
            4, 5: return 3;
            6, 7: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int rto_exp(int l);
        case (l)
            1: return 120;
            2: return 195;
            default: return 255;
        endcase
    endfunction

    int n_cmp  = 0;
    int n_fail = 0;
    bit saw_chg;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock; outputs are compared against the model at the falling edge.
    task automatic tick();
        @(posedge clk_19);
        @(negedge clk_19);
        chk("lvl",     int'(bus.lvl),     int'(m.lvl));
        chk("age",     int'(bus.age),     age_exp(int'(m.lvl)));
        chk("rto",     int'(bus.rto),     rto_exp(int'(m.lvl)));
        chk("lvl_chg", int'(bus.lvl_chg), int'(m.chg));
        chk("at_min",  int'(bus.at_min),  int'(m.lvl == 4'd1));
        chk("at_max",  int'(bus.at_max),  int'(m.lvl == 4'(NUM_LVL)));
        if (bus.lvl_chg) saw_chg = 1'b1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_raw(input int idx, input logic v);
        case (idx)
            0: bus.lft   = v;
            1: bus.rgt   = v;
            default: bus.cout0 = v;
        endcase
    endtask

    task automatic press(input int idx, input int hold, input int gap);
        set_raw(idx, 1'b1);
        ticks(hold);
        set_raw(idx, 1'b0);
        ticks(gap);
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.lft   = 1'b0;
        bus.rgt   = 1'b0;
        bus.cout0 = 1'b0;
        ticks(3);
        chk("rst_lvl",    int'(bus.lvl),     1);
        chk("rst_age",    int'(bus.age),     9);
        chk("rst_rto",    int'(bus.rto),     120);
        chk("rst_chg",    int'(bus.lvl_chg), 0);
        chk("rst_at_min", int'(bus.at_min),  1);
        chk("rst_at_max", int'(bus.at_max),  0);

        rst_n   = 1'b1;
        saw_chg = 1'b0;
        ticks(10);
        chk("idle_lvl", int'(bus.lvl), 1);
        chk("idle_chg", int'(saw_chg), 0);

        // Single long press: level moves exactly 8 edges after the raw rise.
        bus.rgt = 1'b1;
        ticks(7);
        chk("lat7_lvl", int'(bus.lvl), 1);
        tick();
        chk("lat8_lvl", int'(bus.lvl),     2);
        chk("lat8_age", int'(bus.age),     6);
        chk("lat8_rto", int'(bus.rto),     195);
        chk("lat8_chg", int'(bus.lvl_chg), 1);
        saw_chg = 1'b0;
        ticks(2);
        bus.rgt = 1'b0;
        ticks(6);
        chk("held_one_pulse", int'(saw_chg), 0);
        chk("held_lvl",       int'(bus.lvl), 2);

        // Short glitch is rejected.
        press(1, 3, 10);
        chk("abort_lvl", int'(bus.lvl), 2);

        // Back to level 1, then three clean presses.
        do_start();
        chk("start_lvl", int'(bus.lvl), 1);
        for (int i = 0; i < 3; i++) press(1, 7, 5);
`ifdef WAM_LVL_AUTORPT_EN
        chk("three_lvl",    int'(bus.lvl),    4);
        chk("three_at_max", int'(bus.at_max), 0);
`else
        chk("three_lvl",    int'(bus.lvl),    3);
        chk("three_at_max", int'(bus.at_max), 1);
        saw_chg = 1'b0;
        press(1, 7, 5);
        chk("sat_lvl", int'(bus.lvl), 3);
        chk("sat_chg", int'(saw_chg), 0);
`endif

        // Simultaneous easier and harder at level 2: easier wins.
        do_start();
        press(1, 7, 5);
        chk("pre_both_lvl", int'(bus.lvl), 2);
        bus.lft = 1'b1;
        bus.rgt = 1'b1;
        ticks(8);
        chk("both_lvl", int'(bus.lvl), 1);
        bus.lft = 1'b0;
        bus.rgt = 1'b0;
        ticks(5);

        // start in the same cycle as a harder pulse at level 3.
        press(1, 7, 5);
        press(1, 7, 5);
        chk("pre_start_lvl", int'(bus.lvl), 3);
        bus.rgt = 1'b1;
        ticks(7);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("start_rgt_lvl", int'(bus.lvl),     1);
        chk("start_rgt_chg", int'(bus.lvl_chg), 1);
        bus.rgt = 1'b0;
        ticks(5);

        // start at level 1 does not pulse.
        saw_chg = 1'b0;
        do_start();
        tick();
        chk("start1_chg", int'(saw_chg), 0);

        // Long cout0 hold yields exactly one step.
        press(2, 60, 5);
        chk("cout_lvl", int'(bus.lvl), 2);

        // Reset during debounce count 3 with the input held afterwards.
        bus.rgt = 1'b1;
        ticks(5);
        rst_n = 1'b0;
        tick();
        rst_n   = 1'b1;
        saw_chg = 1'b0;
        ticks(30);
        chk("rstdbn_lvl", int'(bus.lvl), 1);
        chk("rstdbn_chg", int'(saw_chg), 0);
        bus.rgt = 1'b0;
        ticks(5);
        press(1, 7, 5);
        chk("rstdbn_recover", int'(bus.lvl), 2);

`ifdef WAM_LVL_AUTORPT_EN
        // Held rgt repeats every RPT cycles; cout0 never repeats.
        do_start();
        press(1, 48, 5);
        chk("rpt_lvl", int'(bus.lvl), 4);
        press(2, 80, 5);
        chk("rpt_cout_lvl", int'(bus.lvl), 5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wam_lvl.md
WAM_LVL -- requirements
Module: wam_lvl

Interface
REQ-001 Parameter NUM_LVL, default 3, SHALL set the number of difficulty levels; legal range 2..8.
REQ-002 Parameter DBN_CYC, default 5, SHALL set consecutive high samples required to accept a press; legal range 2..15.
REQ-003 Parameter RPT_CYC, default 16, SHALL set the held-button repeat period in cycles; legal range 4..255.
REQ-004 Parameter LVL_W, default 3, SHALL set the width of lvl; it must hold NUM_LVL.
REQ-005 Port clk_19, input, 1 bit: single clock; all state SHALL be on its rising edge.
REQ-006 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port start, input, 1 bit: synchronous return to level 1.
REQ-008 Port lft, input, 1 bit: raw "easier" button, asynchronous to clk_19.
REQ-009 Port rgt, input, 1 bit: raw "harder" button, asynchronous to clk_19.
REQ-010 Port cout0, input, 1 bit: raw score-carry "harder" request, asynchronous to clk_19.
REQ-011 Port lvl, output, LVL_W bits: current level, 1..NUM_LVL.
REQ-012 Port age, output, 4 bits: mole lifetime for current level.
REQ-013 Port rto, output, 8 bits: pop-up ratio for current level.
REQ-014 Port lvl_chg, output, 1 bit: one-cycle pulse when lvl changes.
REQ-015 Ports at_min and at_max, output, 1 bit each: lvl==1 and lvl==NUM_LVL respectively.

Function
REQ-016 Each raw input SHALL pass a 2-flop synchroniser and then a debouncer that emits a one-cycle pulse.
REQ-017 Debouncer SHALL arm on a synchronised rising edge and emit its pulse after DBN_CYC consecutive high samples, counting the edge sample.
REQ-018 A low sample before DBN_CYC SHALL abort with no pulse; a held input SHALL yield only one pulse unless WAM_LVL_AUTORPT_EN is defined.
REQ-019 Priority per cycle SHALL be: start, then easier (lft pulse), then harder (rgt pulse OR cout0 pulse); lower-priority events in the same cycle SHALL be discarded.
REQ-020 Easier SHALL decrement lvl and saturate at 1; harder SHALL increment lvl and saturate at NUM_LVL.
REQ-021 lvl, age, rto and lvl_chg SHALL all update on the edge following the accepted pulse: one cycle of latency, with age and rto never lagging lvl.
REQ-022 age and rto SHALL be table lookups. Table index 1..8: age = 9,6,4,3,3,2,2,1; rto = 120,195,255,255,255,255,255,255.
REQ-023 lvl_chg SHALL assert only when lvl actually changes; saturated requests and start at level 1 SHALL NOT pulse.
REQ-024 at_min and at_max SHALL be decoded combinationally from the lvl register.

Reset
REQ-025 While rst_n is low, outputs SHALL be lvl=1, age=9, rto=120, lvl_chg=0, at_min=1, at_max=0.
REQ-026 While rst_n is low, all synchroniser, debounce and repeat state SHALL be cleared.
REQ-027 Reset asserted mid-debounce SHALL discard the pending press; no pulse SHALL follow deassertion unless a new rising edge occurs.

Configuration
REQ-028 Macro WAM_LVL_AUTORPT_EN, when defined, SHALL make lft and rgt repeat while held: an extra pulse every RPT_CYC cycles after the first pulse, until release.
REQ-029 cout0 SHALL never auto-repeat.
REQ-030 When WAM_LVL_AUTORPT_EN is undefined, the repeat counters SHALL be absent and there SHALL be one pulse per press.

Structure
REQ-031 Package wam_pkg SHALL hold the AGE_TBL and RTO_TBL constants (8 entries each) and the level typedef.
REQ-032 Sub-module wam_dbn SHALL implement synchroniser, debounce and optional repeat; wam_lvl SHALL instantiate it three times.

Verification
REQ-033 Reset then idle: lvl=1, age=9, rto=120, at_min=1, no lvl_chg pulse.
REQ-034 rgt high 10 cycles (DBN_CYC=5): one pulse; lvl=2, age=6, rto=195 exactly 2+5+1 cycles after the rise; single lvl_chg pulse.
REQ-035 rgt high 3 cycles then low: no level change. Three clean rgt presses from level 1: lvl reaches 3 and at_max=1; a fourth press gives no change and no lvl_chg.
REQ-036 lft and rgt pulses in the same cycle at level 2: lvl=1. start with rgt pulse in the same cycle at level 3: lvl=1 with lvl_chg.
REQ-037 With WAM_LVL_AUTORPT_EN defined, NUM_LVL=8, RPT_CYC=16: rgt held 40 cycles past its first pulse gives lvl 1 to 4. cout0 held long gives exactly +1.
REQ-038 rst_n pulsed low during debounce count 3: afterwards lvl=1 and no pulse while the input stays high.
